// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 transmit path: state encoding, word geometry and byte lane selection.
// Byte order follows FT245_TX_LITTLE_ENDIAN_EN when defined, big-endian otherwise.
package ft245_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POP     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    localparam int BYTES_PER_WORD = 4;

    // idx is the transmit position within the word; the lane it maps to depends on byte order
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
`ifdef FT245_TX_LITTLE_ENDIAN_EN
        lane = idx;
`else
        lane = 2'd3 - idx;
`endif
        case (lane)
            2'd0:    select_byte = word[7:0];
            2'd1:    select_byte = word[15:8];
            2'd2:    select_byte = word[23:16];
            default: select_byte = word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/ft245_tx_serializer.sv
// Pops 32-bit words from the host-to-FTDI FIFO and streams them as four bytes on a valid/ready interface.
// Define FT245_TX_LITTLE_ENDIAN_EN to send the least significant byte first.
module ft245_tx_serializer
    import ft245_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_rd,
    input  logic                   abort,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [31:0] word_reg;
    logic        handshake;

    assign handshake = byte_valid & byte_ready;
    assign busy      = (state != ST_IDLE);

    // One word per pass: IDLE -> POP -> CAPTURE -> SEND; abort drops whatever is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fifo_rd    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_idx   <= 2'd0;
            word_reg   <= 32'h0;
            word_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd <= 1'b1;
                        state   <= ST_POP;
                    end
                end
                ST_POP: begin
                    fifo_rd <= 1'b0;
                    state   <= abort ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        word_reg   <= fifo_data;
                        byte_data  <= select_byte(fifo_data, 2'd0);
                        byte_valid <= 1'b1;
                        byte_idx   <= 2'd0;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A byte accepted alongside abort is still consumed; only the rest is dropped
                    if (abort) begin
                        byte_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (handshake) begin
                        if (byte_idx != LAST_IDX) begin
                            byte_idx  <= byte_idx + 2'd1;
                            byte_data <= select_byte(word_reg, byte_idx + 2'd1);
                        end else begin
                            byte_valid <= 1'b0;
                            word_count <= word_count + COUNT_WIDTH'(1);
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_tx_serializer.sv
// Self-checking bench for ft245_tx_serializer: FIFO model, handshake monitor and byte-order reference model.
// Honours FT245_TX_LITTLE_ENDIAN_EN so the same bench checks either byte order.
module tb_ft245_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        abort;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic [15:0] word_count;

    logic        fifo_rd_s;
    logic [7:0]  byte_data_s;
    logic        byte_valid_s;
    logic        busy_s;
    logic [2:0]  word_count_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_count = 0;

    ft245_tx_serializer #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .abort(abort), .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .word_count(word_count)
    );

    // Narrow-counter twin shares every input, so its wrap is reachable within a short run
    ft245_tx_serializer #(.COUNT_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd_s),
        .abort(abort), .byte_data(byte_data_s), .byte_valid(byte_valid_s), .byte_ready(byte_ready),
        .busy(busy_s), .word_count(word_count_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after fifo_rd is sampled high
    logic [31:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd && (rd_ptr != wr_ptr)) begin
            fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    function automatic logic [7:0] model_byte(input logic [31:0] w, input int k);
`ifdef FT245_TX_LITTLE_ENDIAN_EN
        return 8'(w >> (8 * k));
`else
        return 8'(w >> (8 * (3 - k)));
`endif
    endfunction

    // Monitor samples 1 time unit before each rising edge, when inputs and outputs are settled
    logic [7:0] rx_bytes[$];
    int         rx_cyc[$];
    int         rd_pulses = 0;
    int         rd_last_cyc = -1;
    int         stall_err = 0;
    int         diverge = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && (!byte_valid || byte_data !== prev_data)) stall_err++;
                if (fifo_rd) begin
                    rd_pulses++;
                    rd_last_cyc = cyc;
                end
                if (byte_valid && byte_ready) begin
                    rx_bytes.push_back(byte_data);
                    rx_cyc.push_back(cyc);
                end
                if (fifo_rd_s !== fifo_rd || byte_valid_s !== byte_valid ||
                    byte_data_s !== byte_data || busy_s !== busy) diverge++;
                prev_hold = byte_valid && !byte_ready && !abort;
                prev_data = byte_data;
            end
        end
    end

    task automatic wait_rx(input int n, input int budget, output bit timed_out);
        int c = 0;
        while (rx_bytes.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        timed_out = (rx_bytes.size() < n);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        abort      = 1'b0;
        byte_ready = 1'b0;
        #2;
        checks += 6;
        if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", byte_valid); end
        if (byte_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 00", byte_data); end
        if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_rd: got %b, expected 0", fifo_rd); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        if (word_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %0d, expected 0", word_count); end
        if (word_count_s !== 3'h0) begin errors++; $display("[TB] FAIL reset_count_small: got %0d, expected 0", word_count_s); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        logic [31:0] w = 32'hDEADBEEF;
        int base = rx_bytes.size();
        int rd0 = rd_pulses;
        int n;
        bit to;
        byte_ready = 1'b1;
        n = cyc;
        push(w);
        wait_rx(base + 4, 20, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL single_timeout: got %0d bytes, expected %0d", rx_bytes.size() - base, 4); end
        for (int k = 0; k < 4; k++) begin
            if (base + k < rx_bytes.size()) begin
                checks += 2;
                if (rx_bytes[base+k] !== model_byte(w, k)) begin
                    errors++; $display("[TB] FAIL single_byte%0d: got %h, expected %h", k, rx_bytes[base+k], model_byte(w, k));
                end
                if (rx_cyc[base+k] != n + 3 + k) begin
                    errors++; $display("[TB] FAIL single_cycle%0d: got %0d, expected %0d", k, rx_cyc[base+k], n + 3 + k);
                end
            end
        end
        repeat (3) @(negedge clk);
        exp_count++;
        checks += 4;
        if (rd_pulses - rd0 != 1) begin errors++; $display("[TB] FAIL single_rd_pulses: got %0d, expected 1", rd_pulses - rd0); end
        if (rd_last_cyc != n + 1) begin errors++; $display("[TB] FAIL single_rd_cycle: got %0d, expected %0d", rd_last_cyc, n + 1); end
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL single_count: got %0d, expected %0d", word_count, exp_count); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_stall;
        logic [31:0] w = 32'hDEADBEEF;
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int base = rx_bytes.size();
        int st0 = stall_err;
        int i = 0;
        push(w);
        while (rx_bytes.size() < base + 4 && i < 60) begin
            byte_ready = pat[i % 7][0];
            @(negedge clk);
            i++;
        end
        byte_ready = 1'b1;
        repeat (5) @(negedge clk);
        exp_count++;
        checks += 3;
        if (rx_bytes.size() != base + 4) begin errors++; $display("[TB] FAIL stall_nbytes: got %0d, expected 4", rx_bytes.size() - base); end
        if (stall_err != st0) begin errors++; $display("[TB] FAIL stall_hold: got %0d violations, expected 0", stall_err - st0); end
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL stall_count: got %0d, expected %0d", word_count, exp_count); end
        for (int k = 0; k < 4; k++) begin
            if (base + k < rx_bytes.size()) begin
                checks++;
                if (rx_bytes[base+k] !== model_byte(w, k)) begin
                    errors++; $display("[TB] FAIL stall_byte%0d: got %h, expected %h", k, rx_bytes[base+k], model_byte(w, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words[3] = '{32'h00010203, 32'h04050607, 32'h08090A0B};
        int base = rx_bytes.size();
        bit to;
        byte_ready = 1'b1;
        for (int j = 0; j < 3; j++) push(words[j]);
        wait_rx(base + 12, 60, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d bytes, expected 12", rx_bytes.size() - base); end
        for (int j = 0; j < 12; j++) begin
            if (base + j < rx_bytes.size()) begin
                checks++;
                if (rx_bytes[base+j] !== model_byte(words[j/4], j % 4)) begin
                    errors++; $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", j, rx_bytes[base+j], model_byte(words[j/4], j % 4));
                end
                if (j > 0) begin
                    checks++;
                    if (rx_cyc[base+j] - rx_cyc[base+j-1] != ((j % 4 == 0) ? 4 : 1)) begin
                        errors++; $display("[TB] FAIL b2b_spacing%0d: got %0d, expected %0d", j,
                                           rx_cyc[base+j] - rx_cyc[base+j-1], (j % 4 == 0) ? 4 : 1);
                    end
                end
            end
        end
        repeat (3) @(negedge clk);
        exp_count += 3;
        checks++;
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL b2b_count: got %0d, expected %0d", word_count, exp_count); end
    endtask

    task automatic test_abort;
        logic [31:0] w0 = 32'h11223344;
        logic [31:0] w1 = 32'h55667788;
        int base = rx_bytes.size();
        bit to;
        byte_ready = 1'b1;
        push(w0);
        wait_rx(base + 2, 20, to);
        abort      = 1'b1;
        byte_ready = 1'b0;
        @(negedge clk);
        abort      = 1'b0;
        byte_ready = 1'b1;
        checks += 4;
        if (to) begin errors++; $display("[TB] FAIL abort_timeout: got %0d bytes, expected 2", rx_bytes.size() - base); end
        if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b, expected 0", byte_valid); end
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL abort_count: got %0d, expected %0d", word_count, exp_count); end
        if (rx_bytes.size() != base + 2) begin errors++; $display("[TB] FAIL abort_nbytes: got %0d, expected 2", rx_bytes.size() - base); end
        push(w1);
        wait_rx(base + 6, 20, to);
        repeat (3) @(negedge clk);
        exp_count++;
        checks += 2;
        if (to) begin errors++; $display("[TB] FAIL abort_next_timeout: got %0d bytes, expected 6", rx_bytes.size() - base); end
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL abort_next_count: got %0d, expected %0d", word_count, exp_count); end
        for (int j = 0; j < 6; j++) begin
            if (base + j < rx_bytes.size()) begin
                logic [7:0] e;
                e = (j < 2) ? model_byte(w0, j) : model_byte(w1, j - 2);
                checks++;
                if (rx_bytes[base+j] !== e) begin
                    errors++; $display("[TB] FAIL abort_byte%0d: got %h, expected %h", j, rx_bytes[base+j], e);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] words[20];
        int base = rx_bytes.size();
        int st0 = stall_err;
        int pushed = 0;
        int c = 0;
        for (int j = 0; j < 20; j++) words[j] = $urandom;
        while (rx_bytes.size() < base + 80 && c < 3000) begin
            if (pushed < 20 && ($urandom % 3) == 0) begin
                push(words[pushed]);
                pushed++;
            end
            byte_ready = (($urandom % 10) < 7);
            @(negedge clk);
            c++;
        end
        byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_count += 20;
        checks += 3;
        if (rx_bytes.size() != base + 80) begin errors++; $display("[TB] FAIL rand_nbytes: got %0d, expected 80", rx_bytes.size() - base); end
        if (stall_err != st0) begin errors++; $display("[TB] FAIL rand_hold: got %0d violations, expected 0", stall_err - st0); end
        if (word_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL rand_count: got %0d, expected %0d", word_count, exp_count); end
        for (int j = 0; j < 80; j++) begin
            if (base + j < rx_bytes.size()) begin
                checks++;
                if (rx_bytes[base+j] !== model_byte(words[j/4], j % 4)) begin
                    errors++; $display("[TB] FAIL rand_byte%0d: got %h, expected %h", j, rx_bytes[base+j], model_byte(words[j/4], j % 4));
                end
            end
        end
    endtask

    task automatic test_wrap;
        checks += 2;
        if (word_count_s !== 3'(exp_count % 8)) begin
            errors++; $display("[TB] FAIL wrap_count_small: got %0d, expected %0d", word_count_s, exp_count % 8);
        end
        if (diverge != 0) begin errors++; $display("[TB] FAIL wrap_twin_outputs: got %0d differing samples, expected 0", diverge); end
    endtask

    task automatic test_reset_mid;
        int rd0;
        int rx0;
        int c = 0;
        byte_ready = 1'b0;
        push(32'hCAFEF00D);
        while (!byte_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!byte_valid) begin errors++; $display("[TB] FAIL rstmid_timeout: got valid %b, expected 1", byte_valid); end
        #2 rst = 1'b1;
        #1;
        exp_count = 0;
        checks += 6;
        if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b, expected 0", byte_valid); end
        if (byte_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data: got %h, expected 00", byte_data); end
        if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_fifo_rd: got %b, expected 0", fifo_rd); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", busy); end
        if (word_count !== 16'h0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d, expected 0", word_count); end
        if (word_count_s !== 3'h0) begin errors++; $display("[TB] FAIL rstmid_count_small: got %0d, expected 0", word_count_s); end
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        byte_ready = 1'b1;
        rd0 = rd_pulses;
        rx0 = rx_bytes.size();
        repeat (10) @(negedge clk);
        checks += 3;
        if (rd_pulses != rd0) begin errors++; $display("[TB] FAIL rstmid_no_pop: got %0d pulses, expected 0", rd_pulses - rd0); end
        if (rx_bytes.size() != rx0) begin errors++; $display("[TB] FAIL rstmid_no_bytes: got %0d bytes, expected 0", rx_bytes.size() - rx0); end
        if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle_valid: got %b, expected 0", byte_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_back_to_back();
        test_abort();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
